// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH cycles,
// with valid/ready handshakes on both the operand and the result side.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_shift;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             fa_sum;
  logic             fa_cout;

  assign fa_sum  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign fa_cout = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                   (b_sh_reg[0] & carry_reg);

  // Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    sum_shift            = sum_reg >> 1;
    sum_shift[WIDTH-1]   = fa_sum;
  end

  assign inReady  = (state_reg == IDLE);
  assign outValid = out_valid_reg;
  assign sum      = sum_reg;
  assign Cout     = cout_reg;
  assign busy     = busy_reg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (inValid) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            carry_reg <= Cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_shift;
          carry_reg <= fa_cout;
          a_sh_reg  <= a_sh_reg >> 1;
          b_sh_reg  <= b_sh_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            cout_reg      <= fa_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (outReady) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus randomised traffic on a
// WIDTH=8 and a WIDTH=1 instance, checked through expected-result queues.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rstn8, inv8, inr8, cin8, outv8, outr8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       rstn1, inv1, inr1, cin1, outv1, outr1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  bit         rr8 = 0;
  bit         rr1 = 0;
  bit         done1 = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rstN(rstn8), .inValid(inv8), .inReady(inr8), .A(a8), .B(b8),
    .Cin(cin8), .outValid(outv8), .outReady(outr8), .sum(sum8), .Cout(cout8),
    .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rstN(rstn1), .inValid(inv1), .inReady(inr1), .A(a1), .B(b1),
    .Cin(cin1), .outValid(outv1), .outReady(outr1), .sum(sum1), .Cout(cout1),
    .busy(busy1)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Golden model: plain integer addition of the sampled operands.
  function automatic logic [8:0] model8(logic [7:0] a, logic [7:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic [1:0] model1(logic a, logic b, logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  always @(negedge clk) if (rr8) outr8 = 1'($urandom_range(0, 1));
  always @(negedge clk) if (rr1) outr1 = 1'($urandom_range(0, 1));

  // Monitors: compare every presented result against the queue head.
  always begin
    @(negedge clk);
    #1;
    if (outv8 !== 1'b0) begin
      if (q8.size() == 0) check("w8 spurious outValid", outv8, 0);
      else begin
        check("w8 sum", sum8, q8[0][7:0]);
        check("w8 cout", cout8, q8[0][8]);
        if (outr8) void'(q8.pop_front());
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (outv1 !== 1'b0) begin
      if (q1.size() == 0) check("w1 spurious outValid", outv1, 0);
      else begin
        check("w1 sum", sum1, q1[0][0]);
        check("w1 cout", cout1, q1[0][1]);
        if (outr1) void'(q1.pop_front());
      end
    end
  end

  // Returns at the falling edge right after the accepting rising edge.
  task automatic issue8(logic [7:0] a, logic [7:0] b, logic c, bit hold);
    int n = 0;
    @(negedge clk);
    inv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    while (!inr8 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin timeout_fail("w8 accept"); inv8 = 1'b0; return; end
    q8.push_back(model8(a, b, c));
    @(posedge clk);
    @(negedge clk);
    if (!hold) inv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic issue1(logic a, logic b, logic c);
    int n = 0;
    @(negedge clk);
    inv1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    while (!inr1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin timeout_fail("w1 accept"); inv1 = 1'b0; return; end
    q1.push_back(model1(a, b, c));
    @(posedge clk);
    @(negedge clk);
    inv1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((q8.size() != 0 || !inr8) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout_fail("w8 drain");
  endtask

  task automatic wait_idle1();
    int n = 0;
    while ((q1.size() != 0 || !inr1) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout_fail("w1 drain");
  endtask

  task automatic check_reset8(string tag);
    check({tag, " inReady"}, inr8, 1);
    check({tag, " outValid"}, outv8, 0);
    check({tag, " busy"}, busy8, 0);
    check({tag, " sum"}, sum8, 0);
    check({tag, " cout"}, cout8, 0);
  endtask

  // WIDTH=1 instance: reset check then random traffic with stalls.
  initial begin
    rstn1 = 1'b0; inv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; outr1 = 1'b1;
    repeat (3) @(negedge clk);
    check("w1 reset inReady", inr1, 1);
    check("w1 reset outValid", outv1, 0);
    rstn1 = 1'b1;
    rr1 = 1;
    for (int i = 0; i < 1000; i++) begin
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle1();
    rr1 = 0;
    outr1 = 1'b1;
    done1 = 1;
  end

  initial begin
    logic [7:0] held_sum;
    logic       held_cout;
    int         n;

    rstn8 = 1'b0; inv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; outr8 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset8("reset");
    rstn8 = 1'b1;

    // Latency and the reference 0x5A+0x3C case.
    issue8(8'h5A, 8'h3C, 1'b0, 0);
    check("t1 busy in run", busy8, 1);
    check("t1 outValid early", outv8, 0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j < 8) check("t1 outValid early", outv8, 0);
      else begin
        check("t1 outValid on time", outv8, 1);
        check("t1 sum const", sum8, 8'h96);
        check("t1 cout const", cout8, 0);
      end
    end
    @(negedge clk);
    check("t1 outValid drop", outv8, 0);
    check("t1 inReady back", inr8, 1);

    issue8(8'hFF, 8'h01, 1'b0, 0);
    wait_idle8();
    check("t2 sum ff+01", sum8, 8'h00);
    check("t2 cout ff+01", cout8, 1);
    issue8(8'hFF, 8'hFF, 1'b1, 0);
    wait_idle8();
    check("t2 sum ff+ff+1", sum8, 8'hFF);
    check("t2 cout ff+ff+1", cout8, 1);

    // Backpressure: result must be frozen while outReady is low.
    outr8 = 1'b0;
    issue8(8'hA7, 8'h6B, 1'b1, 0);
    n = 0;
    while (!outv8 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("t3 outValid");
    held_sum = 8'hA7 + 8'h6B + 8'h01;
    held_cout = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3 stall outValid", outv8, 1);
      check("t3 stall sum", sum8, held_sum);
      check("t3 stall cout", cout8, held_cout);
      check("t3 stall inReady", inr8, 0);
    end
    outr8 = 1'b1;
    @(negedge clk);
    check("t3 release outValid", outv8, 0);
    check("t3 release inReady", inr8, 1);

    // Inputs churn and inValid stays high through RUN and a stalled DONE.
    outr8 = 1'b0;
    issue8(8'h3D, 8'hC4, 1'b0, 1);
    for (int j = 0; j < 10; j++) begin
      check("t4 inReady low", inr8, 0);
      check("t4 busy high", busy8, 1);
      @(negedge clk);
      inv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    inv8 = 1'b0;
    outr8 = 1'b1;
    wait_idle8();
    check("t4 sum", sum8, 8'h01);
    check("t4 cout", cout8, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN abandons the operation.
    issue8(8'h77, 8'h11, 1'b1, 0);
    repeat (3) @(negedge clk);
    void'(q8.pop_back());
    rstn8 = 1'b0;
    #1;
    check_reset8("t5 midrun");
    repeat (2) @(negedge clk);
    check("t5 no outValid", outv8, 0);
    rstn8 = 1'b1;
    issue8(8'h01, 8'h01, 1'b0, 0);
    wait_idle8();
    check("t5 sum after reset", sum8, 8'h02);
    check("t5 cout after reset", cout8, 0);

    rr8 = 1;
    for (int i = 0; i < 1000; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle8();
    rr8 = 0;
    outr8 = 1'b1;

    n = 0;
    while (!done1 && n < 50000) begin @(negedge clk); n++; end
    if (!done1) timeout_fail("w1 random run");
    repeat (3) @(negedge clk);
    check("w8 results outstanding", q8.size(), 0);
    check("w1 results outstanding", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
